// File: rtl/fft_pkg.sv
// Shared sizing for the FFT front end: default sample width, frame length and
// the sample type used by FFT_Top and the frame buffer feeding it.
package fft_pkg;
   localparam int SAMPLE_SIZE = 32;
   localparam int BUFFER_SIZE = 32;
   localparam int IDX_W       = $clog2(BUFFER_SIZE);

   typedef logic signed [SAMPLE_SIZE-1:0] sample_t;
endpackage

// File: rtl/fft_frame_bank.sv
// One frame bank: buffer_size samples held in a flat register vector, written
// one sample at a time by index and exposed whole as the frame bus.
module fft_frame_bank
   import fft_pkg::*;
#(
   parameter int sample_size = SAMPLE_SIZE,
   parameter int buffer_size = BUFFER_SIZE,
   localparam int idx_w      = $clog2(buffer_size),
   localparam int frame_w    = sample_size * buffer_size
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          wr_en,
   input  logic [idx_w-1:0]              wr_idx,
   input  logic signed [sample_size-1:0] wr_data,
   output logic [frame_w-1:0]            frame
);

   logic [frame_w-1:0] frame_q;
   logic [frame_w-1:0] frame_d;

   always_comb begin
      frame_d = frame_q;
      if (wr_en) begin
         frame_d[int'(wr_idx)*sample_size +: sample_size] = wr_data;
      end
   end

   // Banks are cleared on reset so the presented bus reads zero afterwards.
   always_ff @(posedge clk) begin
      if (reset) begin
         frame_q <= '0;
      end else begin
         frame_q <= frame_d;
      end
   end

   assign frame = frame_q;

endmodule

// File: rtl/fft_frame_buffer.sv
// Double-buffered frame collector: packs buffer_size samples per bank and
// presents completed banks to the FFT stage with a valid/ready handshake.
module fft_frame_buffer
   import fft_pkg::*;
#(
   parameter int sample_size = SAMPLE_SIZE,
   parameter int buffer_size = BUFFER_SIZE,
   localparam int idx_w      = $clog2(buffer_size),
   localparam int frame_w    = sample_size * buffer_size
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic signed [sample_size-1:0] s_data,
   input  logic                          s_valid,
   output logic                          s_ready,
   output logic [frame_w-1:0]            frame_bitstream,
   output logic                          frame_valid,
   input  logic                          frame_ready,
   output logic [7:0]                    frame_seq
);

   logic [idx_w-1:0]   wr_idx_q,  wr_idx_d;
   logic               wr_bank_q, wr_bank_d;
   logic               rd_bank_q, rd_bank_d;
   logic [1:0]         full_q,    full_d;
   logic [7:0]         seq_q,     seq_d;

   logic               accept;
   logic               rel;
   logic               last_idx;
   logic [1:0]         bank_wr_en;
   logic [frame_w-1:0] bank_frame [2];

   assign last_idx = (wr_idx_q == idx_w'(buffer_size - 1));

   always_comb begin
      s_ready     = !reset && !full_q[wr_bank_q];
      frame_valid = full_q[rd_bank_q];
      accept      = s_valid && s_ready;
      rel         = frame_valid && frame_ready;

      wr_idx_d  = wr_idx_q;
      wr_bank_d = wr_bank_q;
      rd_bank_d = rd_bank_q;
      full_d    = full_q;
      seq_d     = seq_q;

      // Release and last-sample accept never target the same bank: accept needs
      // the write bank empty, release needs the read bank full.
      if (rel) begin
         full_d[rd_bank_q] = 1'b0;
         rd_bank_d         = !rd_bank_q;
         seq_d             = seq_q + 8'd1;
      end

      if (accept) begin
         wr_idx_d = wr_idx_q + 1'b1;
         if (last_idx) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = !wr_bank_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_idx_q  <= '0;
         wr_bank_q <= 1'b0;
         rd_bank_q <= 1'b0;
         full_q    <= 2'b00;
         seq_q     <= 8'd0;
      end else begin
         wr_idx_q  <= wr_idx_d;
         wr_bank_q <= wr_bank_d;
         rd_bank_q <= rd_bank_d;
         full_q    <= full_d;
         seq_q     <= seq_d;
      end
   end

   for (genvar i = 0; i < 2; i++) begin : g_bank
      assign bank_wr_en[i] = accept && (wr_bank_q == 1'(i));

      fft_frame_bank #(
         .sample_size (sample_size),
         .buffer_size (buffer_size)
      ) u_bank (
         .clk     (clk),
         .reset   (reset),
         .wr_en   (bank_wr_en[i]),
         .wr_idx  (wr_idx_q),
         .wr_data (s_data),
         .frame   (bank_frame[i])
      );
   end

   always_comb begin
      frame_bitstream = bank_frame[rd_bank_q];
   end

   assign frame_seq = seq_q;

endmodule

// File: tb/tb_fft_frame_buffer.sv
// Scoreboard bench for fft_frame_buffer: completed frames are queued as samples
// are accepted and compared while presented and on release.
module tb_fft_frame_buffer;
   import fft_pkg::*;

   localparam int SW = 32;
   localparam int BS = 32;
   localparam int FW = SW * BS;

   logic                 clk = 1'b0;
   logic                 reset = 1'b1;
   logic signed [SW-1:0] s_data = '0;
   logic                 s_valid = 1'b0;
   logic                 s_ready;
   logic [FW-1:0]        frame_bitstream;
   logic                 frame_valid;
   logic                 frame_ready = 1'b0;
   logic [7:0]           frame_seq;

   always #5 clk = ~clk;

   fft_frame_buffer #(
      .sample_size (SW),
      .buffer_size (BS)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .s_data          (s_data),
      .s_valid         (s_valid),
      .s_ready         (s_ready),
      .frame_bitstream (frame_bitstream),
      .frame_valid     (frame_valid),
      .frame_ready     (frame_ready),
      .frame_seq       (frame_seq)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_checks++;
      if (obs !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
      end
   endtask

   // Reference model: partial frame being collected, queue of complete frames
   logic [FW-1:0] exp_q [$];
   logic [FW-1:0] part;
   int            part_n;
   logic [7:0]    seq_m;
   int            rdy_mode = 0;  // 0 low, 1 high, 2 random, 3 driven by the test

   initial begin
      part   = '0;
      part_n = 0;
      seq_m  = 8'd0;
      forever begin
         @(negedge clk);
         if (reset) begin
            exp_q.delete();
            part   = '0;
            part_n = 0;
            seq_m  = 8'd0;
         end else begin
            logic m_valid, m_ready;
            m_valid = (exp_q.size() > 0);
            m_ready = (exp_q.size() < 2);
            chk("s_ready", 64'(s_ready), 64'(m_ready));
            chk("frame_valid", 64'(frame_valid), 64'(m_valid));
            if (m_valid) begin
               chk("frame_seq", 64'(frame_seq), 64'(seq_m));
               for (int k = 0; k < BS; k++) begin
                  chk($sformatf("slice%0d", k), 64'(frame_bitstream[k*SW +: SW]),
                      64'(exp_q[0][k*SW +: SW]));
               end
            end
            if (m_valid && frame_ready) begin
               void'(exp_q.pop_front());
               seq_m = seq_m + 8'd1;
            end
            if (s_valid && m_ready) begin
               part[part_n*SW +: SW] = s_data;
               part_n++;
               if (part_n == BS) begin
                  exp_q.push_back(part);
                  part_n = 0;
               end
            end
         end
      end
   end

   initial forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
         0: frame_ready = 1'b0;
         1: frame_ready = 1'b1;
         2: frame_ready = 1'($urandom_range(0, 1));
         default: ;
      endcase
   end

   task automatic do_reset(input int n);
      reset   = 1'b1;
      s_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      chk("rst_valid", 64'(frame_valid), 64'd0);
      chk("rst_seq", 64'(frame_seq), 64'd0);
      chk("rst_bus_zero", 64'(frame_bitstream == '0), 64'd1);
      chk("rst_s_ready", 64'(s_ready), 64'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [SW-1:0] v);
      int t;
      t       = 0;
      s_data  = v;
      s_valid = 1'b1;
      @(negedge clk);
      while (!s_ready && t < 300) begin
         @(negedge clk);
         t++;
      end
      if (t >= 300) chk("send_timeout", 64'd0, 64'd1);
      @(posedge clk);
      #1;
      s_valid = 1'b0;
   endtask

   task automatic drain();
      int t;
      t        = 0;
      rdy_mode = 1;
      @(negedge clk);
      while (exp_q.size() != 0 && t < 300) begin
         @(negedge clk);
         t++;
      end
      if (t >= 300) chk("drain_timeout", 64'd0, 64'd1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Fill one frame and hold, then a second, then stall
      do_reset(3);
      rdy_mode = 0;
      for (int i = 0; i < BS; i++) send(SW'(i));
      @(negedge clk);
      chk("hold_valid", 64'(frame_valid), 64'd1);
      chk("hold_seq", 64'(frame_seq), 64'd0);
      chk("hold_slice0", 64'(frame_bitstream[0 +: SW]), 64'd0);
      chk("hold_slice31", 64'(frame_bitstream[31*SW +: SW]), 64'd31);
      @(posedge clk);
      #1;
      for (int i = BS; i < 2*BS; i++) send(SW'(i));
      @(negedge clk);
      chk("both_full_stall", 64'(s_ready), 64'd0);
      @(posedge clk);
      #1;
      drain();
      chk("hold_seq_after", 64'(frame_seq), 64'd2);

      // Negative values and bit-exactness
      rdy_mode = 0;
      send(SW'(-100));
      send(32'h7fff_ffff);
      send(32'h8000_0000);
      send(SW'(5));
      for (int i = 4; i < BS; i++) send($urandom);
      @(negedge clk);
      chk("neg_slice0", 64'(frame_bitstream[0 +: SW]), 64'hffff_ff9c);
      chk("neg_slice1", 64'(frame_bitstream[SW +: SW]), 64'h7fff_ffff);
      chk("neg_slice2", 64'(frame_bitstream[2*SW +: SW]), 64'h8000_0000);
      chk("neg_slice3", 64'(frame_bitstream[3*SW +: SW]), 64'd5);
      @(posedge clk);
      #1;
      drain();

      // Random downstream readiness
      rdy_mode = 2;
      for (int i = 0; i < 3*BS; i++) send($urandom);
      drain();

      // Continuous streaming with frame_ready high
      do_reset(2);
      rdy_mode = 1;
      for (int i = 0; i < 3*BS; i++) send(SW'(1000 + i));
      drain();
      chk("stream_seq", 64'(frame_seq), 64'd3);

      // Release of frame 0 coincides with acceptance of sample 63
      do_reset(2);
      rdy_mode    = 3;
      frame_ready = 1'b0;
      for (int i = 0; i < 2*BS-1; i++) send(SW'(i));
      frame_ready = 1'b1;
      send(SW'(63));
      frame_ready = 1'b0;
      @(negedge clk);
      chk("sim_valid", 64'(frame_valid), 64'd1);
      chk("sim_s_ready", 64'(s_ready), 64'd1);
      chk("sim_seq", 64'(frame_seq), 64'd1);
      chk("sim_slice0", 64'(frame_bitstream[0 +: SW]), 64'd32);
      chk("sim_slice31", 64'(frame_bitstream[31*SW +: SW]), 64'd63);
      @(posedge clk);
      #1;
      drain();

      // Reset mid-frame discards the partial frame
      rdy_mode = 0;
      for (int i = 0; i < 17; i++) send(SW'(500 + i));
      do_reset(1);
      rdy_mode = 0;
      for (int i = 0; i < BS; i++) send(SW'(100 + i));
      @(negedge clk);
      chk("mid_valid", 64'(frame_valid), 64'd1);
      chk("mid_seq", 64'(frame_seq), 64'd0);
      chk("mid_slice0", 64'(frame_bitstream[0 +: SW]), 64'd100);
      chk("mid_slice31", 64'(frame_bitstream[31*SW +: SW]), 64'd131);
      @(posedge clk);
      #1;
      drain();

      // frame_seq wraps after 256 frames
      do_reset(2);
      rdy_mode = 1;
      for (int f = 0; f < 256; f++) begin
         for (int i = 0; i < BS; i++) send(SW'(f*BS + i));
      end
      drain();
      chk("wrap_seq", 64'(frame_seq), 64'd0);
      chk("wrap_valid", 64'(frame_valid), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fft_frame_buffer.md
# fft_frame_buffer

Double-buffered frame collector directly upstream of `FFT_Top`. It accepts one signed audio sample per handshake and packs `buffer_size` consecutive samples into the flat frame bus that `FFT_Top.input_bitstream` consumes. It presents each completed frame with a valid/ready handshake. Two banks let capture of frame N+1 proceed while the FFT stage holds frame N.

## Interface
- `sample_size`, default 32: width of one signed sample, in bits.
- `buffer_size`, default 32: samples per frame; must be a power of two and ≥ 2.
- `clk`  in  1: sole clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `s_data`  in  `sample_size`: signed input sample.
- `s_valid`  in  1: `s_data` is valid this cycle.
- `s_ready`  out  1: buffer can accept a sample this cycle.
- `frame_bitstream`  out  `sample_size*buffer_size`: sample k of the frame sits at `[k*sample_size +: sample_size]`; k=0 is the oldest sample.
- `frame_valid`  out  1: `frame_bitstream` holds a complete frame.
- `frame_ready`  in  1: downstream consumes the frame.
- `frame_seq`  out  8: count of frames presented, modulo 256.

## Operation
- Sample accept occurs when `s_valid && s_ready`. The sample is written to the write bank at index `wr_idx`, then `wr_idx` increments.
- When `wr_idx` wraps from `buffer_size-1` to 0, the write bank is marked full and the write pointer toggles to the other bank.
- State per bank: EMPTY or FULL (`full[1:0]`). `wr_bank` and `rd_bank` are 1-bit pointers.
- `s_ready = !full[wr_bank]` while `reset` is low. It is forced to 0 while `reset` is high.
- Backpressure: if both banks are FULL, `s_ready` is 0 and incoming samples are not lost. The source holds them.
- Frame presentation: `frame_valid = full[rd_bank]`, and `frame_bitstream` comes from bank `rd_bank`.
- Frame release occurs when `frame_valid && frame_ready`. On release, `full[rd_bank]` clears, `rd_bank` toggles, and `frame_seq` increments (wrapping 255 to 0).
- While `frame_valid` is high and `frame_ready` is low, `frame_bitstream` and `frame_seq` are stable.
- When `frame_valid` is low, `frame_bitstream` reflects the bank `rd_bank` points to. Its contents there are unspecified except after reset.
- Simultaneous events in one cycle: if the last-sample accept into bank B and the release of bank A coincide, both take effect. The next cycle shows B FULL and presented, A EMPTY as the write bank, and `s_ready` at 1.
- Reset in mid-operation discards any partial frame and any FULL banks. No partial frame is ever presented.
- No arithmetic on sample values; samples are stored bit-exact.

## Timing
- Reset values:
  - `frame_valid` = 0.
  - `frame_seq` = 0.
  - `frame_bitstream` = 0 (both banks cleared).
  - `wr_idx`, `wr_bank` and `rd_bank` = 0.
  - `s_ready` = 1 in the first cycle after `reset` falls.
- Latency: if the final sample of a frame is accepted at edge E, `frame_valid` is 1 immediately after E.
- Throughput: one sample per cycle sustained, provided each frame is released within `buffer_size` cycles of presentation.
- After a release at edge E:
  - If the other bank was FULL, it is presented after E, giving back-to-back `frame_valid`.
  - If the writer was stalled, `s_ready` rises after E.
- No combinational path from `s_valid` or `frame_ready` to any output.

## Structure
- Shared package `fft_pkg` holds:
  - `SAMPLE_SIZE` = 32 and `BUFFER_SIZE` = 32 as defaults shared with `FFT_Top`;
  - `typedef logic signed [SAMPLE_SIZE-1:0] sample_t`;
  - the `IDX_W = $clog2(BUFFER_SIZE)` constant.
- Sub-module `fft_frame_bank` is a single bank: a `buffer_size`×`sample_size` register array with write-enable and index, exposing the flat frame bus. It is instantiated twice; the top level holds the pointers, the full flags and the output mux.

## Test plan
- Fill one frame and hold: reset, then stream samples 0..31 with `frame_ready` low.
  - `frame_valid` rises the cycle after sample 31.
  - Slice k equals k; `frame_seq` = 0.
  - `s_ready` stays 1 for the next 32 samples, then drops to 0.
- Negative values and bit-exactness: stream `-100, 2^31-1, -2^31, 5, ...`. Each slice matches its sample bit-exact, including the sign.
- Continuous streaming: stream 96 samples at 1/cycle with `frame_ready` tied high.
  - Three frames are presented, each for one cycle; `frame_seq` reaches 3.
  - `s_ready` never drops.
- Simultaneous events: time the release of frame 0 to coincide with acceptance of sample 63.
  - The next cycle shows frame 1 (values 32..63) valid and `s_ready` = 1.
  - No sample is duplicated or lost.
- Reset mid-frame: accept 17 samples, then pulse `reset` for 1 cycle, then stream 32 new samples 100..131.
  - The first frame presented holds 100..131; `frame_seq` = 0.
- `frame_seq` wrap: complete 256 frames with `frame_ready` high. `frame_seq` wraps from 255 to 0 and `frame_valid` timing is unchanged.
